// File: rtl/sub_share_arb.sv
// Round-robin arbiter sharing one subtractor across NREQ requesters, with a single registered response slot.
// Define SUB_SHARE_ARB_SAT_EN to clamp underflowing results to zero (borrow still reported).
module sub_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_ci,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_diff,
    output logic                    rsp_borrow
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_diff_q, rsp_diff_d;
    logic             rsp_borrow_q, rsp_borrow_d;

    logic             can_accept_c;
    logic             found_c;
    logic             transfer_c;
    logic [IDW-1:0]   sel_idx_c;
    logic [IDW-1:0]   idx_c;
    logic [WIDTH-1:0] a_sel_c, b_sel_c;
    logic             ci_sel_c;
    logic [WIDTH:0]   diff_full_c;
    logic [WIDTH-1:0] diff_res_c;

    assign can_accept_c = (state_q == ST_EMPTY) | (rsp_valid_q & rsp_ready);

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        found_c   = 1'b0;
        sel_idx_c = '0;
        idx_c     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = IDW'((32'(ptr_q) + k) % NREQ);
            if (!found_c && req_valid[idx_c]) begin
                found_c   = 1'b1;
                sel_idx_c = idx_c;
            end
        end
    end

    assign transfer_c = found_c & can_accept_c & ~rst;

    always_comb begin
        req_ready = '0;
        if (transfer_c) begin
            req_ready[sel_idx_c] = 1'b1;
        end
    end

    // Shared subtractor on the granted operands.
    always_comb begin
        a_sel_c     = req_a[32'(sel_idx_c)*WIDTH +: WIDTH];
        b_sel_c     = req_b[32'(sel_idx_c)*WIDTH +: WIDTH];
        ci_sel_c    = req_ci[sel_idx_c];
        diff_full_c = {1'b0, a_sel_c} - {1'b0, b_sel_c} - {{WIDTH{1'b0}}, ci_sel_c};
`ifdef SUB_SHARE_ARB_SAT_EN
        diff_res_c  = diff_full_c[WIDTH] ? '0 : diff_full_c[WIDTH-1:0];
`else
        diff_res_c  = diff_full_c[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_diff_d   = rsp_diff_q;
        rsp_borrow_d = rsp_borrow_q;
        case (state_q)
            ST_EMPTY: begin
                rsp_valid_d = 1'b0;
            end
            ST_FULL: begin
                if (rsp_ready) begin
                    state_d     = ST_EMPTY;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                rsp_valid_d = 1'b0;
            end
        endcase
        // A grant always refills the slot, including the same-cycle drain case.
        if (transfer_c) begin
            state_d      = ST_FULL;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = sel_idx_c;
            rsp_diff_d   = diff_res_c;
            rsp_borrow_d = diff_full_c[WIDTH];
            ptr_d        = IDW'((32'(sel_idx_c) + 32'd1) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_diff_q   <= '0;
            rsp_borrow_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_diff_q   <= rsp_diff_d;
            rsp_borrow_q <= rsp_borrow_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_diff   = rsp_diff_q;
    assign rsp_borrow = rsp_borrow_q;

endmodule

// File: tb/tb_sub_share_arb.sv
// Directed vector bench for sub_share_arb (NREQ=4, WIDTH=8), plus latency and fairness sequences.
module tb_sub_share_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ci;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_diff;
    logic        rsp_borrow;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SUB_SHARE_ARB_SAT_EN
    localparam logic [7:0] WRAP = 8'h00;
    localparam logic [7:0] NEG  = 8'h00;
`else
    localparam logic [7:0] WRAP = 8'hFF;
    localparam logic [7:0] NEG  = 8'hF0;
`endif

    // Operand set 1: r0 10-01-0=0F, r1 20-02-0=1E, r2 35-12-1=22, r3 00-00-1=wrap
    localparam logic [31:0] A1  = {8'h00, 8'h35, 8'h20, 8'h10};
    localparam logic [31:0] B1  = {8'h00, 8'h12, 8'h02, 8'h01};
    // Operand set 2: r1 becomes 10-20-0 (negative)
    localparam logic [31:0] A2  = {8'h00, 8'h35, 8'h10, 8'h10};
    localparam logic [31:0] B2  = {8'h00, 8'h12, 8'h20, 8'h01};
    localparam logic [3:0]  CI  = 4'b1100;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        rsp_ready;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [7:0]  exp_diff;
        logic        exp_borrow;
    } vec_t;

    vec_t vq[$];

    sub_share_arb #(.NREQ(4), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ci     (req_ci),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_diff   (rsp_diff),
        .rsp_borrow (rsp_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] a,
                                input logic [31:0] b, input logic rr, input logic [3:0] er,
                                input logic ev, input logic [1:0] eid, input logic [7:0] ed,
                                input logic eb);
        vec_t t;
        t.rst = r; t.valid = v; t.a = a; t.b = b; t.rsp_ready = rr;
        t.exp_ready = er; t.exp_valid = ev; t.exp_id = eid; t.exp_diff = ed; t.exp_borrow = eb;
        return t;
    endfunction

    initial begin
        int lat;
        int exp_id;
        //               rst valid    a   b   rr  ready    v  id  diff   bor
        vq.push_back(mk(1, 4'b1111, A1, B1, 1, 4'b0000, 0, 0, 8'h00, 0)); // 0 reset
        vq.push_back(mk(1, 4'b1111, A1, B1, 1, 4'b0000, 0, 0, 8'h00, 0)); // 1 reset
        vq.push_back(mk(0, 4'b1111, A1, B1, 1, 4'b0001, 0, 0, 8'h00, 0)); // 2 grant r0
        vq.push_back(mk(0, 4'b1111, A1, B1, 1, 4'b0010, 1, 0, 8'h0F, 0)); // 3
        vq.push_back(mk(0, 4'b1111, A1, B1, 1, 4'b0100, 1, 1, 8'h1E, 0)); // 4
        vq.push_back(mk(0, 4'b1111, A1, B1, 1, 4'b1000, 1, 2, 8'h22, 0)); // 5
        vq.push_back(mk(0, 4'b1111, A1, B1, 1, 4'b0001, 1, 3, WRAP,  1)); // 6 wrap
        vq.push_back(mk(0, 4'b1111, A1, B1, 0, 4'b0000, 1, 0, 8'h0F, 0)); // 7 backpressure x5
        vq.push_back(mk(0, 4'b1111, A1, B1, 0, 4'b0000, 1, 0, 8'h0F, 0)); // 8
        vq.push_back(mk(0, 4'b1111, A1, B1, 0, 4'b0000, 1, 0, 8'h0F, 0)); // 9
        vq.push_back(mk(0, 4'b1111, A1, B1, 0, 4'b0000, 1, 0, 8'h0F, 0)); // 10
        vq.push_back(mk(0, 4'b1111, A1, B1, 0, 4'b0000, 1, 0, 8'h0F, 0)); // 11
        vq.push_back(mk(0, 4'b1111, A1, B1, 1, 4'b0010, 1, 0, 8'h0F, 0)); // 12 drain+refill
        vq.push_back(mk(0, 4'b0000, A1, B1, 1, 4'b0000, 1, 1, 8'h1E, 0)); // 13
        vq.push_back(mk(0, 4'b0000, A1, B1, 1, 4'b0000, 0, 1, 8'h1E, 0)); // 14 drained, fields kept
        vq.push_back(mk(0, 4'b0001, A1, B1, 1, 4'b0001, 0, 1, 8'h1E, 0)); // 15 wrap search
        vq.push_back(mk(0, 4'b0010, A2, B2, 1, 4'b0010, 1, 0, 8'h0F, 0)); // 16
        vq.push_back(mk(0, 4'b0000, A2, B2, 0, 4'b0000, 1, 1, NEG,   1)); // 17 negative
        vq.push_back(mk(0, 4'b1000, A1, B1, 0, 4'b0000, 1, 1, NEG,   1)); // 18
        vq.push_back(mk(0, 4'b1000, A1, B1, 1, 4'b1000, 1, 1, NEG,   1)); // 19
        vq.push_back(mk(1, 4'b0000, A1, B1, 0, 4'b0000, 1, 3, WRAP,  1)); // 20 reset while full
        vq.push_back(mk(0, 4'b1111, A1, B1, 0, 4'b0001, 0, 0, 8'h00, 0)); // 21 ptr back to 0
        vq.push_back(mk(0, 4'b1111, A1, B1, 1, 4'b0010, 1, 0, 8'h0F, 0)); // 22
        vq.push_back(mk(0, 4'b0000, A1, B1, 1, 4'b0000, 1, 1, 8'h1E, 0)); // 23

        req_ci = CI;
        foreach (vq[i]) begin
            rst       = vq[i].rst;
            req_valid = vq[i].valid;
            req_a     = vq[i].a;
            req_b     = vq[i].b;
            rsp_ready = vq[i].rsp_ready;
            @(negedge clk);
            check($sformatf("v%0d req_ready", i),  32'(req_ready),  32'(vq[i].exp_ready));
            check($sformatf("v%0d rsp_valid", i),  32'(rsp_valid),  32'(vq[i].exp_valid));
            check($sformatf("v%0d rsp_id", i),     32'(rsp_id),     32'(vq[i].exp_id));
            check($sformatf("v%0d rsp_diff", i),   32'(rsp_diff),   32'(vq[i].exp_diff));
            check($sformatf("v%0d rsp_borrow", i), 32'(rsp_borrow), 32'(vq[i].exp_borrow));
            @(posedge clk);
            #1;
        end

        // Single op from requester 2 (pointer now 2): response exactly one cycle later.
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single req_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        lat = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("single latency", 32'(lat), 32'd1);
        check("single rsp_id", 32'(rsp_id), 32'd2);
        check("single rsp_diff", 32'(rsp_diff), 32'h22);
        check("single rsp_borrow", 32'(rsp_borrow), 32'd0);

        // Fairness: all valid, pointer at 3 -> 3,0,1,2,... one response per cycle.
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            exp_id = (3 + n) % 4;
            @(negedge clk);
            check($sformatf("rr%0d req_ready", n), 32'(req_ready), 32'(4'b0001 << exp_id));
            if (n > 0) begin
                check($sformatf("rr%0d rsp_valid", n), 32'(rsp_valid), 32'd1);
                check($sformatf("rr%0d rsp_id", n), 32'(rsp_id), 32'((exp_id + 3) % 4));
            end
            @(posedge clk);
            #1;
        end
        req_valid = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_share_arb.md
Name: sub_share_arb

Overview:
- Round-robin arbiter and sequencer sharing one WIDTH-bit subtractor between NREQ requesters.
- Each accepted request computes DIFF = A - B - CI and presents it on a single registered response channel, tagged with the requester index.
- Sits between datapath clients and the shared subtractor macro, so only one subtractor instance is needed per cluster.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result width in bits.
- IDW, $clog2(NREQ), width of the requester-index tag (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; at most one bit high per cycle.
- req_a  input  NREQ*WIDTH  minuends; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  subtrahends, same packing as req_a.
- req_ci  input  NREQ  borrow-in per requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_diff  output  WIDTH  (A - B - CI) mod 2^WIDTH.
- rsp_borrow  output  1  1 when A < B + CI (unsigned).

Behaviour:
- Reset (rst=1 at a rising edge):
  - rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_borrow=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - FSM goes to EMPTY.
  - Any held result is discarded, not delivered.
  - req_ready is all-zero while rst=1.
- FSM, 2 states:
  - EMPTY: output register free.
  - FULL: rsp_valid=1 and the result is held stable until rsp_ready=1.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant (combinational):
  - When can_accept=1 and rst=0, req_ready is one-hot on the first i with req_valid[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - Otherwise req_ready is all-zero.
  - req_ready may depend on req_valid.
  - Requesters must not make req_valid depend on req_ready, and must hold valid and operands stable until granted.
- Transfer occurs on a cycle where req_valid[i] & req_ready[i]. At the following edge:
  - rsp_diff, rsp_borrow and rsp_id=i load from the selected operands.
  - rsp_valid=1.
  - ptr = (i+1) mod NREQ.
  - FSM goes to FULL.
- Latency is 1 cycle: a request accepted in cycle k is visible on the response outputs in cycle k+1.
- Throughput is 1 result/cycle when rsp_ready is held high; the same-cycle drain-and-refill path keeps state FULL.
- Drain with no new grant (rsp_valid & rsp_ready, and no req_valid set) → EMPTY, rsp_valid=0. rsp_diff, rsp_id and rsp_borrow retain their last value.
- FULL & !rsp_ready → all req_ready=0. Outputs hold; ptr holds.
- No request granted → ptr unchanged.
- Arithmetic: compute the WIDTH+1-bit quantity {1'b0,A} - {1'b0,B} - CI.
  - rsp_diff is its low WIDTH bits.
  - rsp_borrow is bit WIDTH.
  - Wrap-around: 0 - 0 - 1 gives diff all-ones, borrow=1.
- Starvation bound: a requester holding req_valid is granted within NREQ accepts.

Optional Feature:
- Macro: SUB_SHARE_ARB_SAT_EN.
- Defined: saturating mode.
  - When the computed borrow is 1, rsp_diff is forced to 0.
  - rsp_borrow still reports 1, flagging saturation.
- Undefined: modular result as above. No saturation logic is synthesized.

Test Plan:
- Reset check: assert rst for 2 cycles with all req_valid=1 → req_ready=0 throughout. After release, all outputs are 0, then requester 0 is granted in the first cycle.
- Single op: req 2 sends A=0x35, B=0x12, CI=1, rsp_ready=1 → the next cycle shows rsp_valid=1, rsp_id=2, rsp_diff=0x22, rsp_borrow=0.
- Borrow/wrap:
  - A=0x00, B=0x00, CI=1 → diff=0xFF, borrow=1.
  - A=0x10, B=0x20, CI=0 → diff=0xF0, borrow=1.
  - With SUB_SHARE_ARB_SAT_EN defined, both give diff=0x00, borrow=1.
- Round-robin fairness: all 4 requesters hold valid, rsp_ready=1 → grant order 0,1,2,3,0,… with one response every cycle and no bubbles.
- Backpressure: hold rsp_ready=0 for 5 cycles while FULL with pending requests → response stable, req_ready=0. When rsp_ready rises, drain and the next grant happen in the same cycle, and the next response appears 1 cycle later.
- Reset mid-operation: while FULL with rsp_id=3, assert rst one cycle → rsp_valid=0 next cycle, ptr=0, the held result is never delivered.
